// File: rtl/pdm_sampler_pkg.sv
// rtl/pdm_sampler_pkg.sv - shared constants and types for the PDM microphone front end
//
// Purpose: divider defaults, FSM state type and channel indices shared by
//          pdm_sampler, pdm_clk_gen and the downstream CIC-pair wrapper.
// Ports:   none (package).

package pdm_sampler_pkg;

    localparam int                   PDM_DIV_W       = 8;
    localparam logic [PDM_DIV_W-1:0] PDM_DIV_DEFAULT = 8'd24;

    typedef enum logic {
        PDM_IDLE = 1'b0,
        PDM_RUN  = 1'b1
    } pdm_state_t;

    localparam int PDM_CH_L = 0;
    localparam int PDM_CH_R = 1;

endpackage

// File: rtl/pdm_clk_gen.sv
// rtl/pdm_clk_gen.sv - PDM clock generator with glitch-free divider update
//
// Purpose: two-state run/idle FSM, half-period counter and pdm_clk register.
//          Reports each half-period boundary as a combinational tick so the
//          capture registers update on the same edge as pdm_clk.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   en                run enable
//   div, div_we       new half-period divider value and its write strobe
//   pdm_clk           registered microphone clock
//   rise_tick         end of low phase this cycle (pdm_clk about to rise)
//   fall_tick         end of high phase this cycle (pdm_clk about to fall)

module pdm_clk_gen
    import pdm_sampler_pkg::*;
#(
    parameter int               DIV_W       = PDM_DIV_W,
    parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(PDM_DIV_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             div_we,
    output logic             pdm_clk,
    output logic             rise_tick,
    output logic             fall_tick
);

    pdm_state_t       state, state_nxt;
    logic [DIV_W-1:0] half_cntr, half_cntr_nxt;
    logic [DIV_W-1:0] div_num, div_num_nxt;
    logic [DIV_W-1:0] div_pend;
    logic             pdm_clk_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PDM_IDLE;
            half_cntr <= '0;
            div_num   <= DIV_DEFAULT;
            div_pend  <= DIV_DEFAULT;
            pdm_clk   <= 1'b0;
        end else begin
            state     <= state_nxt;
            half_cntr <= half_cntr_nxt;
            div_num   <= div_num_nxt;
            pdm_clk   <= pdm_clk_nxt;
            if (div_we) begin
                div_pend <= div;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        half_cntr_nxt = half_cntr;
        div_num_nxt   = div_num;
        pdm_clk_nxt   = pdm_clk;
        rise_tick     = 1'b0;
        fall_tick     = 1'b0;
        case (state)
            PDM_IDLE: begin
                half_cntr_nxt = '0;
                pdm_clk_nxt   = 1'b0;
                if (en) begin
                    state_nxt = PDM_RUN;
                end
            end
            PDM_RUN: begin
                if (!en) begin
                    // Stopping suppresses any boundary in this cycle.
                    state_nxt     = PDM_IDLE;
                    half_cntr_nxt = '0;
                    pdm_clk_nxt   = 1'b0;
                end else if (half_cntr == div_num) begin
                    half_cntr_nxt = '0;
                    pdm_clk_nxt   = ~pdm_clk;
                    rise_tick     = ~pdm_clk;
                    fall_tick     = pdm_clk;
                    // A write landing on the boundary itself still counts for
                    // the next half-period, so bypass div_pend here.
                    div_num_nxt   = div_we ? div : div_pend;
                end else begin
                    half_cntr_nxt = half_cntr + 1'b1;
                end
            end
            default: begin
                state_nxt     = PDM_IDLE;
                half_cntr_nxt = '0;
                pdm_clk_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pdm_sampler.sv
// rtl/pdm_sampler.sv - PDM clock generation and left/right bit capture
//
// Purpose: drives the microphone clock and splits the shared data line into
//          left (captured at end of high phase) and right (captured at end of
//          low phase) bit streams with one-cycle new_data strobes.
// Config:  PDM_SAMPLER_STEREO_EN defined -> both channels captured;
//          undefined -> left only, din_r/new_data_r tied to 0.
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   en                    run enable (low parks pdm_clk low)
//   div, div_we           half-period divider value and write strobe
//   pdm_data              microphone data line, asynchronous to clk
//   pdm_clk               registered microphone clock
//   din_l, new_data_l     left bit and its update strobe
//   din_r, new_data_r     right bit and its update strobe

module pdm_sampler
    import pdm_sampler_pkg::*;
#(
    parameter int               DIV_W       = PDM_DIV_W,
    parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(PDM_DIV_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             div_we,
    input  logic             pdm_data,
    output logic             pdm_clk,
    output logic             din_l,
    output logic             new_data_l,
    output logic             din_r,
    output logic             new_data_r
);

    logic sync_1, sync_2;
    logic rise_tick, fall_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pdm_data;
            sync_2 <= sync_1;
        end
    end

    pdm_clk_gen #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div       (div),
        .div_we    (div_we),
        .pdm_clk   (pdm_clk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_l      <= 1'b0;
            new_data_l <= 1'b0;
        end else begin
            new_data_l <= fall_tick;
            if (fall_tick) begin
                din_l <= sync_2;
            end
        end
    end

`ifdef PDM_SAMPLER_STEREO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_r      <= 1'b0;
            new_data_r <= 1'b0;
        end else begin
            new_data_r <= rise_tick;
            if (rise_tick) begin
                din_r <= sync_2;
            end
        end
    end
`else
    logic unused_rise_tick;
    assign unused_rise_tick = rise_tick;
    assign din_r            = 1'b0;
    assign new_data_r       = 1'b0;
`endif

endmodule

// File: tb/tb_pdm_sampler.sv
// tb/tb_pdm_sampler.sv - scoreboard bench for pdm_sampler

module tb_pdm_sampler;
    import pdm_sampler_pkg::*;

    localparam int PAT_N = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] div;
    logic       div_we;
    logic       pdm_data;
    logic       pdm_clk;
    logic       din_l;
    logic       new_data_l;
    logic       din_r;
    logic       new_data_r;

    pdm_sampler dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div        (div),
        .div_we     (div_we),
        .pdm_data   (pdm_data),
        .pdm_clk    (pdm_clk),
        .din_l      (din_l),
        .new_data_l (new_data_l),
        .din_r      (din_r),
        .new_data_r (new_data_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_no;
        int ch;
        int bit_v;
    } ev_t;

    ev_t  sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic pat [0:PAT_N-1];
    int   t0, t1, t2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected strobes at boundary edges; the captured bit is the pin value
    // two edges before the boundary.
    task automatic push_events(input int first, input int step, input int count, input bit first_rise);
        for (int i = 0; i < count; i++) begin
            int  e;
            bit  rise;
            ev_t ev;
            e    = first + i * step;
            rise = first_rise ? (i % 2 == 0) : (i % 2 == 1);
            ev.edge_no = e;
            ev.bit_v   = int'(pat[e-2]);
            if (rise) begin
`ifdef PDM_SAMPLER_STEREO_EN
                ev.ch = PDM_CH_R;
                sb.push_back(ev);
`endif
            end else begin
                ev.ch = PDM_CH_L;
                sb.push_back(ev);
            end
        end
    endtask

    task automatic fill_rand(input int from, input int to);
        for (int k = from; k <= to; k++) pat[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_cyc(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pdm_clk"}, int'(pdm_clk), 0);
        check({tag, "_din_l"}, int'(din_l), 0);
        check({tag, "_new_data_l"}, int'(new_data_l), 0);
        check({tag, "_din_r"}, int'(din_r), 0);
        check({tag, "_new_data_r"}, int'(new_data_r), 0);
    endtask

    // Pin driver: value presented for edge k is pat[k].
    initial begin
        forever begin
            @(negedge clk);
            pdm_data = (cyc + 1 < PAT_N) ? pat[cyc+1] : 1'b0;
        end
    end

    // Monitor / scoreboard pop.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (new_data_l || new_data_r)) begin
                if (new_data_l && new_data_r) check("both_strobes", 1, 0);
                if (sb.size() == 0) begin
                    check("sb_unexpected", int'(new_data_r) * 2 + int'(new_data_l), 0);
                end else begin
                    ev_t ev;
                    ev = sb.pop_front();
                    check("sb_cycle", cyc, ev.edge_no);
                    check("sb_chan", new_data_l ? PDM_CH_L : PDM_CH_R, ev.ch);
                    check("sb_bit", new_data_l ? int'(din_l) : int'(din_r), ev.bit_v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < PAT_N; k++) pat[k] = 1'b0;
        rst      = 1'b1;
        en       = 1'b0;
        div      = 8'd0;
        div_we   = 1'b0;
        pdm_data = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Default divider, data follows pdm_clk level -> L=1, R=0.
        t0 = cyc + 1;
        for (int k = t0; k <= t0 + 114; k++) pat[k] = 1'(((k - t0) / 25) % 2);
        push_events(t0 + 25, 25, 4, 1'b1);
        en = 1'b1;
        wait_cyc(t0 + 24);
        check("a_low_phase", int'(pdm_clk), 0);
        wait_cyc(t0 + 25);
        check("a_first_rise", int'(pdm_clk), 1);
        wait_cyc(t0 + 110);

        // Divider change to 3 during a high phase.
        fill_rand(t0 + 115, t0 + 400);
        push_events(t0 + 125, 25, 2, 1'b1);
        push_events(t0 + 154, 4, 7, 1'b1);
        wait_cyc(t0 + 130);
        div    = 8'd3;
        div_we = 1'b1;
        @(negedge clk);
        div_we = 1'b0;
        wait_cyc(t0 + 149);
        check("b_high_kept", int'(pdm_clk), 1);
        wait_cyc(t0 + 150);
        check("b_fall_at_25", int'(pdm_clk), 0);
        wait_cyc(t0 + 153);
        check("b_low_4", int'(pdm_clk), 0);
        wait_cyc(t0 + 154);
        check("b_rise_after_4", int'(pdm_clk), 1);

        // Drop en mid high phase.
        wait_cyc(t0 + 179);
        check("b_high_before_stop", int'(pdm_clk), 1);
        en = 1'b0;
        @(negedge clk);
        check("stop_clk_low", int'(pdm_clk), 0);
        wait_cyc(t0 + 200);
        check("drain_b", sb.size(), 0);

        // Two writes in idle (last wins = 0); restart uses previous div 3.
        div    = 8'd7;
        div_we = 1'b1;
        @(negedge clk);
        div = 8'd0;
        @(negedge clk);
        div_we = 1'b0;
        t1 = cyc + 1;
        fill_rand(t1, t1 + 60);
        push_events(t1 + 4, 1, 1, 1'b1);
        push_events(t1 + 5, 1, 11, 1'b0);
        push_events(t1 + 18, 3, 3, 1'b1);
        en = 1'b1;
        wait_cyc(t1 + 3);
        check("c_full_low", int'(pdm_clk), 0);
        wait_cyc(t1 + 4);
        check("c_rise", int'(pdm_clk), 1);
        wait_cyc(t1 + 5);
        check("c_div0_toggle", int'(pdm_clk), 0);

        // Write on a boundary cycle while div is 0.
        wait_cyc(t1 + 14);
        div    = 8'd2;
        div_we = 1'b1;
        @(negedge clk);
        div_we = 1'b0;

        // Asynchronous reset mid-run.
        wait_cyc(t1 + 25);
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_rst");
        check("drain_c", sb.size(), 0);
        @(negedge clk);

        // After reset the divider is back to 24.
        t2 = cyc + 1;
        fill_rand(t2, t2 + 70);
        push_events(t2 + 25, 25, 2, 1'b1);
        rst = 1'b0;
        wait_cyc(t2 + 24);
        check("e_low_phase", int'(pdm_clk), 0);
        wait_cyc(t2 + 25);
        check("e_rise_div24", int'(pdm_clk), 1);
        wait_cyc(t2 + 55);
        check("drain_e", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
